// File: rtl/diff_bcd_display.sv
// Converts a 5-bit two's-complement difference to sign + two BCD digits (double dabble)
// and scans the result onto a 4-digit common-anode display. Optional macro: DISP_ZERO_BLANK_EN.
module diff_bcd_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic       sign,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned ITER_N = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [1:0] state, state_d;
    logic [2:0] iter;
    logic [4:0] mag;
    logic [7:0] bcd;
    logic       sign_r;

    logic       accept_c, last_c;
    logic [4:0] mag_in_c;
    logic [2:0] adj_hi_c;
    logic [3:0] adj_lo_c;
    logic [7:0] bcd_shift_c;
    logic [4:0] mag_shift_c;

    logic       sign_d;
    logic [3:0] tens_d, ones_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0] idx, idx_d;
    logic [3:0] an_d;
    logic [6:0] seg_d;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'h40;
            4'd1:    digit_seg = 7'h79;
            4'd2:    digit_seg = 7'h24;
            4'd3:    digit_seg = 7'h30;
            4'd4:    digit_seg = 7'h19;
            4'd5:    digit_seg = 7'h12;
            4'd6:    digit_seg = 7'h02;
            4'd7:    digit_seg = 7'h78;
            4'd8:    digit_seg = 7'h00;
            4'd9:    digit_seg = 7'h10;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    assign accept_c = in_valid && in_ready;
    assign last_c   = (state == CONV) && (iter == 3'(ITER_N - 1));
    assign mag_in_c = in_data[4] ? 5'(~in_data + 5'd1) : in_data;

    // One double-dabble iteration; the tens nibble never exceeds 1, so its carry bit is dropped.
    always_comb begin
        adj_hi_c    = (bcd[7:4] >= 4'd5) ? 3'(bcd[7:4] + 4'd3) : bcd[6:4];
        adj_lo_c    = (bcd[3:0] >= 4'd5) ? 4'(bcd[3:0] + 4'd3) : bcd[3:0];
        bcd_shift_c = {adj_hi_c, adj_lo_c, mag[4]};
        mag_shift_c = {mag[3:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept_c) state_d = CONV;
            CONV:    if (last_c)   state_d = DONE;
            DONE:    state_d = accept_c ? CONV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working registers for the conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r <= 1'b0;
            mag    <= '0;
            bcd    <= '0;
            iter   <= '0;
        end else if (accept_c) begin
            sign_r <= in_data[4] && (mag_in_c != 5'd0);
            mag    <= mag_in_c;
            bcd    <= '0;
            iter   <= '0;
        end else if (state == CONV) begin
            mag    <= mag_shift_c;
            bcd    <= bcd_shift_c;
            iter   <= iter + 3'd1;
        end
    end

    // Result values as they will be after this edge, so seg tracks sign/tens/ones exactly.
    always_comb begin
        sign_d = last_c ? sign_r : sign;
        tens_d = last_c ? bcd_shift_c[7:4] : tens;
        ones_d = last_c ? bcd_shift_c[3:0] : ones;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            tens      <= '0;
            ones      <= '0;
        end else begin
            in_ready  <= (state_d != CONV);
            out_valid <= last_c;
            sign      <= sign_d;
            tens      <= tens_d;
            ones      <= ones_d;
        end
    end

    always_comb begin
        cnt_d = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        idx_d = (cnt == CNT_MAX) ? idx + 2'd1 : idx;
        an_d  = 4'b0111;
        seg_d = SEG_BLANK;
        case (idx_d)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = digit_seg(ones_d);
            end
            2'd1: begin
                an_d  = 4'b1101;
`ifdef DISP_ZERO_BLANK_EN
                if (tens_d == 4'd0) seg_d = sign_d ? SEG_MINUS : SEG_BLANK;
                else                seg_d = digit_seg(tens_d);
`else
                seg_d = digit_seg(tens_d);
`endif
            end
            2'd2: begin
                an_d  = 4'b1011;
`ifdef DISP_ZERO_BLANK_EN
                seg_d = (sign_d && (tens_d != 4'd0)) ? SEG_MINUS : SEG_BLANK;
`else
                seg_d = sign_d ? SEG_MINUS : SEG_BLANK;
`endif
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    // Free-running digit scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            an  <= 4'b1110;
            seg <= 7'h40;
        end else begin
            cnt <= cnt_d;
            idx <= idx_d;
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_diff_bcd_display.sv
// Self-checking bench for diff_bcd_display: directed and random differences against an
// arithmetic reference model (signed value, /10 and %10, time-based scan index).
module tb_diff_bcd_display;

    localparam int unsigned RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = 5'd0;
    logic       in_ready, out_valid, sign;
    logic [3:0] tens, ones, an;
    logic [6:0] seg;

    diff_bcd_display #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .sign(sign),
        .tens(tens), .ones(ones), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    // Clock edges elapsed since reset release; the scan index follows from it directly.
    int ticks = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) ticks <= 0;
        else     ticks <= ticks + 1;
    end

    int errors = 0;
    int checks = 0;

    bit         m_ready = 1'b1;
    bit         m_valid = 1'b0;
    int         ph = 0;
    logic [4:0] pend = 5'd0;
    bit         e_sign = 1'b0;
    int         e_tens = 0;
    int         e_ones = 0;

    function automatic logic [6:0] dseg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int i);
        case (i)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        case (i)
            0: return dseg(e_ones);
`ifdef DISP_ZERO_BLANK_EN
            1: return (e_tens == 0) ? (e_sign ? 7'h3F : 7'h7F) : dseg(e_tens);
            2: return (e_sign && e_tens != 0) ? 7'h3F : 7'h7F;
`else
            1: return dseg(e_tens);
            2: return e_sign ? 7'h3F : 7'h7F;
`endif
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_result(input logic [4:0] d);
        int v, m;
        v = d[4] ? int'(d) - 32 : int'(d);
        m = (v < 0) ? -v : v;
        e_sign = (v < 0);
        e_tens = m / 10;
        e_ones = m % 10;
    endtask

    task automatic check_all();
        int i;
        i = (ticks / RD) % 4;
        chk("in_ready",  32'(in_ready),  32'(m_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("sign",      32'(sign),      32'(e_sign));
        chk("tens",      32'(tens),      e_tens);
        chk("ones",      32'(ones),      e_ones);
        chk("an",        32'(an),        32'(exp_an(i)));
        chk("seg",       32'(seg),       32'(exp_seg(i)));
    endtask

    // One clock: update the model at the edge, compare at the following falling edge.
    task automatic step();
        @(posedge clk);
        if (in_valid && m_ready) begin
            pend    = in_data;
            ph      = 1;
            m_ready = 1'b0;
        end else if (ph != 0) begin
            ph++;
        end
        @(negedge clk);
        m_valid = (ph == 6);
        if (m_valid) begin
            apply_result(pend);
            m_ready = 1'b1;
            ph      = 0;
        end
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic offer(input logic [4:0] d);
        while (!m_ready) step();
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ph      = 0;
        m_ready = 1'b1;
        m_valid = 1'b0;
        e_sign  = 1'b0;
        e_tens  = 0;
        e_ones  = 0;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        #2;
        do_reset();
        chk("reset_an", 32'(an), 32'(4'b1110));
        chk("reset_seg", 32'(seg), 32'(7'h40));
        run(16);

        offer(5'b01111);
        run(5);
        chk("p15_tens", 32'(tens), 1);
        chk("p15_ones", 32'(ones), 5);
        run(4);

        offer(5'b10000);
        run(20);
        chk("m16_ones", 32'(ones), 6);

        offer(5'b11111);
        run(17);
        chk("m1_sign", 32'(sign), 1);
        offer(5'b00000);
        run(8);
        chk("zero_sign", 32'(sign), 0);

        // Source holds valid with data changing every cycle.
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_data = 5'($urandom);
            step();
        end
        in_valid = 1'b0;
        run(8);

        offer(5'b00111);
        run(2);
        do_reset();
        run(8);
        offer(5'b11001);
        run(5);
        chk("m7_ones", 32'(ones), 7);
        run(4);

        for (int k = 0; k < 15; k++) begin
            run(int'($urandom_range(0, 3)));
            offer(5'($urandom));
        end
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
